// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiply pipeline: operand
// classes, flag bit positions and exponent helper functions.
package fp_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_cls_e;

  // flags = {invalid, overflow, underflow, inexact}
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_W         = 4;

  localparam int STAGES = 3;

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final stage of the multiplier: normalize the raw significand product,
// round to nearest even, choose special results and pack the output word.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign,
  input  fp_cls_e                  cls_a,
  input  fp_cls_e                  cls_b,
  input  logic signed [EXP_W+1:0]  exp_sum,
  input  logic [2*MAN_W+1:0]       prod,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [FLAG_W-1:0]        flags
);

  localparam int PW  = 2 * (MAN_W + 1);
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] EMAX = EW2'(exp_max(EXP_W));
  localparam logic [EXP_W+MAN_W:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic                  msb, g, r, st, inc;
  logic [MAN_W-1:0]      frac;
  logic [MAN_W:0]        frac_r;
  logic signed [EW2-1:0] e_fin;
  logic                  nan_in, snan_in, inf_zero, any_inf, any_zero;

  // Normalize to one leading integer bit, then RNE round; a carry out of
  // the fraction bumps the exponent (the fraction is already zero then).
  always_comb begin
    msb = prod[PW-1];
    if (msb) begin
      frac = prod[PW-2 -: MAN_W];
      g    = prod[PW-2-MAN_W];
      r    = prod[PW-3-MAN_W];
      st   = |prod[PW-4-MAN_W:0];
    end else begin
      frac = prod[PW-3 -: MAN_W];
      g    = prod[PW-3-MAN_W];
      r    = prod[PW-4-MAN_W];
      st   = |prod[PW-5-MAN_W:0];
    end
    inc    = g & (frac[0] | r | st);
    frac_r = {1'b0, frac} + (MAN_W+1)'(inc);
    e_fin  = exp_sum + EW2'(msb) + EW2'(frac_r[MAN_W]);
  end

  // Special-operand priority: NaN / inf*0, then inf, then zero, then the
  // rounded finite result with overflow/underflow saturation.
  always_comb begin
    nan_in   = (cls_a == CLS_QNAN) || (cls_a == CLS_SNAN) ||
               (cls_b == CLS_QNAN) || (cls_b == CLS_SNAN);
    snan_in  = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN);
    inf_zero = ((cls_a == CLS_INF) && (cls_b == CLS_ZERO)) ||
               ((cls_a == CLS_ZERO) && (cls_b == CLS_INF));
    any_inf  = (cls_a == CLS_INF) || (cls_b == CLS_INF);
    any_zero = (cls_a == CLS_ZERO) || (cls_b == CLS_ZERO);
    result   = '0;
    flags    = '0;
    if (nan_in || inf_zero) begin
      result              = QNAN;
      flags[FLAG_INVALID] = snan_in || inf_zero;
    end else if (any_inf) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (any_zero) begin
      result = {sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (!e_fin[EW2-1] && (e_fin >= EMAX)) begin
      result               = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags[FLAG_OVERFLOW] = 1'b1;
      flags[FLAG_INEXACT]  = 1'b1;
    end else if (e_fin[EW2-1] || (e_fin == '0)) begin
      result                = {sign, {(EXP_W+MAN_W){1'b0}}};
      flags[FLAG_UNDERFLOW] = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      result              = {sign, e_fin[EXP_W-1:0], frac_r[MAN_W-1:0]};
      flags[FLAG_INEXACT] = g | r | st;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier with a global stall:
// S1 unpack/classify, S2 significand multiply + exponent add,
// S3 normalize/round/pack (fp_round_pack) into the output register.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [FLAG_W-1:0]        flags
);

  localparam int XLEN = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 1;
  localparam int PW   = 2 * SW;
  localparam int EW2  = EXP_W + 2;
  localparam logic signed [EW2-1:0] BIAS = EW2'(exp_bias(EXP_W));

  function automatic fp_cls_e classify(input logic [XLEN-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = x[MAN_W +: EXP_W];
    f = x[MAN_W-1:0];
    if (e == '0) return CLS_ZERO;   // subnormals flush to zero
    if (e != '1) return CLS_NORMAL;
    if (f == '0) return CLS_INF;
    return f[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
  endfunction

  logic [STAGES:1]       vld_pipe;
  logic                  advance;

  logic                  s1_sign;
  fp_cls_e               s1_cls_a, s1_cls_b;
  logic [EXP_W-1:0]      s1_ea, s1_eb;
  logic [SW-1:0]         s1_ma, s1_mb;

  logic                  s2_sign;
  fp_cls_e               s2_cls_a, s2_cls_b;
  logic signed [EW2-1:0] s2_exp;
  logic [PW-1:0]         s2_prod;

  logic [XLEN-1:0]       rp_result;
  logic [FLAG_W-1:0]     rp_flags;

  // Whole pipe moves together; it only freezes when the output is held.
  assign advance   = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  // Stage valid bits shift with the pipe; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst)          vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // S1/S2 datapath; payload of bubbles is don't-care, guarded by vld_pipe.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign  <= a[XLEN-1] ^ b[XLEN-1];
      s1_cls_a <= classify(a);
      s1_cls_b <= classify(b);
      s1_ea    <= a[MAN_W +: EXP_W];
      s1_eb    <= b[MAN_W +: EXP_W];
      s1_ma    <= {1'b1, a[MAN_W-1:0]};
      s1_mb    <= {1'b1, b[MAN_W-1:0]};

      s2_sign  <= s1_sign;
      s2_cls_a <= s1_cls_a;
      s2_cls_b <= s1_cls_b;
      s2_exp   <= $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - BIAS;
      s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
    end
  end

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign    (s2_sign),
    .cls_a   (s2_cls_a),
    .cls_b   (s2_cls_b),
    .exp_sum (s2_exp),
    .prod    (s2_prod),
    .result  (rp_result),
    .flags   (rp_flags)
  );

  // S3 output register; holds while stalled so the consumer sees stable data.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      flags  <= '0;
    end else if (advance && vld_pipe[STAGES-1]) begin
      result <= rp_result;
      flags  <= rp_flags;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: reset, basic products, special cases,
// stall/backpressure streaming, mid-flight reset and a half-precision build.
module tb_fp_mul_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_result;
  logic [3:0]  h_flags;

  int n_checks = 0;
  int n_fail   = 0;

  fp_mul_pipe u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_half (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (h_in_valid),
    .in_ready  (h_in_ready),
    .a         (h_a),
    .b         (h_b),
    .out_valid (h_out_valid),
    .out_ready (h_out_ready),
    .result    (h_result),
    .flags     (h_flags)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one pair into an idle pipe and wait (bounded) for its result.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic [3:0] f,
                       output int lat);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    r = result;
    f = flags;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (result !== 32'h0) begin
      n_fail++; $display("FAIL reset_result: got %h expected 00000000", result);
    end
    n_checks++;
    if (flags !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", flags);
    end
    n_checks++;
    if (h_out_valid !== 1'b0 || h_result !== 16'h0) begin
      n_fail++; $display("FAIL reset_half: got valid %b result %h expected 0 0000", h_out_valid, h_result);
    end
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    tick();
  endtask

  task automatic test_basic;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    do_op(32'h3FC00000, 32'h40000000, r, f, lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat);
    end
    n_checks++;
    if (r !== 32'h40400000) begin
      n_fail++; $display("FAIL basic_result: got %h expected 40400000", r);
    end
    n_checks++;
    if (f !== 4'b0000) begin
      n_fail++; $display("FAIL basic_flags: got %b expected 0000", f);
    end
  endtask

  task automatic test_specials;
    logic [31:0] va[5], vb[5], vr[5];
    logic [3:0]  vf[5];
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    va = '{32'h3F800001, 32'h7F800000, 32'h7F000000, 32'h00800000, 32'h7F800001};
    vb = '{32'h3F800001, 32'h00000000, 32'h40000000, 32'h3F000000, 32'h3F800000};
    vr = '{32'h3F800002, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000};
    vf = '{4'b0001,      4'b1000,      4'b0101,      4'b0011,      4'b1000};
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], r, f, lat);
      n_checks++;
      if (r !== vr[i]) begin
        n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", i, r, vr[i]);
      end
      n_checks++;
      if (f !== vf[i]) begin
        n_fail++; $display("FAIL special_flags[%0d]: got %b expected %b", i, f, vf[i]);
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] av[6], bv[6], ev[6];
    logic [35:0] got[$];
    int          sent, stall_left;
    logic        saw_block, first_seen, held_valid;
    logic [31:0] held_res;
    logic [3:0]  held_fl;
    av = '{32'h3FC00000, 32'h40000000, 32'h3F800000, 32'h40400000, 32'hC0000000, 32'h3F000000};
    bv = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h40800000};
    ev = '{32'h40400000, 32'h40800000, 32'h3F800000, 32'h41100000, 32'hC0400000, 32'h40000000};
    sent = 0; stall_left = 0; saw_block = 0; first_seen = 0; held_valid = 0;
    held_res = '0; held_fl = '0;
    for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
      if (held_valid) begin
        n_checks++;
        if (out_valid !== 1'b1 || result !== held_res || flags !== held_fl) begin
          n_fail++;
          $display("FAIL stall_hold: got v%b %h %b expected v1 %h %b",
                   out_valid, result, flags, held_res, held_fl);
        end
      end
      out_ready = (stall_left == 0);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        a = av[sent];
        b = bv[sent];
      end
      #1;
      if (!in_ready) saw_block = 1'b1;
      held_valid = out_valid && !out_ready;
      held_res   = result;
      held_fl    = flags;
      if (out_valid && out_ready) begin
        got.push_back({flags, result});
        if (!first_seen) begin
          first_seen = 1'b1;
          stall_left = 5;
        end
      end else if (stall_left > 0) begin
        stall_left--;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (got.size() !== 6) begin
      n_fail++; $display("FAIL stall_count: got %0d results expected 6", got.size());
    end
    n_checks++;
    if (saw_block !== 1'b1) begin
      n_fail++; $display("FAIL stall_in_ready: got no in_ready drop expected a drop");
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== {4'b0000, ev[i]}) begin
        n_fail++; $display("FAIL stall_order[%0d]: got %h expected %h", i, got[i], {4'b0000, ev[i]});
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_flight;
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 32'h40000000; b = 32'h40000000;
    tick();
    a = 32'h40400000; b = 32'h40400000;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'b0000) begin
      n_fail++; $display("FAIL flight_reset_out: got v%b %h %b expected v0 00000000 0000", out_valid, result, flags);
    end
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flight_in_ready: got %b expected 1", in_ready);
    end
    in_valid = 1'b1; a = 32'h3FC00000; b = 32'h3FC00000;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL flight_latency: got %0d expected 3", lat);
    end
    n_checks++;
    if (result !== 32'h40100000 || flags !== 4'b0000) begin
      n_fail++; $display("FAIL flight_result: got %h %b expected 40100000 0000", result, flags);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flight_extra: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_param;
    int lat;
    h_a = 16'h3E00; h_b = 16'h4000; h_in_valid = 1'b1; h_out_ready = 1'b1;
    tick();
    h_in_valid = 1'b0;
    lat = 1;
    while (!h_out_valid && lat < 10) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL half_latency: got %0d expected 3", lat);
    end
    n_checks++;
    if (h_result !== 16'h4200) begin
      n_fail++; $display("FAIL half_result: got %h expected 4200", h_result);
    end
    n_checks++;
    if (h_flags !== 4'b0000) begin
      n_fail++; $display("FAIL half_flags: got %b expected 0000", h_flags);
    end
    tick();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0;
    test_reset();
    test_basic();
    test_specials();
    test_stall();
    test_reset_flight();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 The block SHALL use parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL use parameter MAN_W, default 23, meaning stored fraction width; XLEN = 1+EXP_W+MAN_W is derived, not set.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand pair a/b present.
REQ-007 in_ready  output  1  pipeline accepts an operand pair this cycle.
REQ-008 a, b  input  XLEN  IEEE-754-format operands {sign, exp, frac}.
REQ-009 out_valid  output  1  result/flags valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  XLEN  product.
REQ-012 flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-013 The block SHALL be a 3-stage pipeline: S1 unpack/classify, S2 significand multiply ((MAN_W+1)x(MAN_W+1)) and exponent add, S3 normalize/round/pack.
REQ-014 A pair SHALL be accepted when in_valid && in_ready; its result SHALL appear with out_valid exactly 3 cycles later when unstalled.
REQ-015 Global stall: advance = !out_valid || out_ready; in_ready = advance; all stages SHALL hold when advance is 0.
REQ-016 Each stage SHALL carry a valid bit; bubbles propagate, so throughput is one result per cycle with out_ready high.
REQ-017 result/flags SHALL stay stable while out_valid && !out_ready.
REQ-018 Sign = sign(a) XOR sign(b) for all non-NaN results.
REQ-019 Exponent SHALL be computed signed at EXP_W+2 bits: ea+eb-BIAS(+1 if product MSB set), BIAS = 2^(EXP_W-1)-1.
REQ-020 Rounding SHALL be round-to-nearest-even using guard, round and sticky (OR of all discarded bits); mantissa carry-out after rounding SHALL increment the exponent.
REQ-021 Subnormal inputs (exp=0) SHALL be treated as signed zero (flush-to-zero).
REQ-022 Final exponent >= 2^EXP_W-1 SHALL give signed infinity, flags overflow=1, inexact=1.
REQ-023 Final exponent <= 0 SHALL give signed zero, flags underflow=1, inexact=1.
REQ-024 Any NaN input, or infinity x zero, SHALL give canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0); invalid=1 for inf x zero or signalling NaN input.
REQ-025 Infinity x nonzero finite SHALL give signed infinity, flags 0; zero x finite SHALL give signed zero, flags 0.
REQ-026 inexact SHALL be 1 whenever guard|round|sticky is nonzero on a normal result.

Reset
REQ-027 While rst is high on a clock edge, all stage valid bits SHALL clear; out_valid=0, result=0, flags=0 the following cycle.
REQ-028 Reset mid-operation SHALL discard all in-flight pairs; no result for them ever appears.
REQ-029 in_ready SHALL be 1 in the first cycle after reset releases.

Structure
REQ-030 A shared package fp_pkg SHALL hold the class encoding (ZERO, NORMAL, INF, QNAN, SNAN), the flag bit positions, and BIAS/exp-width helper constants.
REQ-031 One sub-module fp_round_pack (S3 normalize, RNE round, special-case select, pack) SHALL be instantiated; S1/S2 stay inline.

Verification
REQ-032 0x3FC00000 x 0x40000000 -> result 0x40400000, flags 4'b0000, out_valid 3 cycles after accept.
REQ-033 0x3F800001 x 0x3F800001 -> 0x3F800002, flags 4'b0001; 0x7F800000 x 0x00000000 -> 0x7FC00000, flags 4'b1000.
REQ-034 0x7F000000 x 0x40000000 -> 0x7F800000, flags 4'b0101; 0x00800000 x 0x3F000000 -> 0x00000000, flags 4'b0011.
REQ-035 Stream 6 pairs, out_ready low for 5 cycles after the first result -> in_ready drops once the pipeline is full, no loss or duplication, order preserved, held output stable.
REQ-036 Assert rst with 2 pairs in flight -> out_valid 0 next cycle, neither result emerges, a new pair after release completes in 3 cycles.
REQ-037 Parameter sweep EXP_W=5, MAN_W=10: 0x3E00 x 0x4000 -> 0x4200, flags 4'b0000.
